// File: rtl/pulse_link_pkg.sv
// rtl/pulse_link_pkg.sv - shared constants and types for the pulse-parameter return link
//
// Holds the readback frame header, byte count, per-field byte indices,
// the frame FSM state enum, the serializer state enum and the flags-byte
// bit positions.
package pulse_link_pkg;

    localparam logic [7:0] RB_HEADER      = 8'hA5;
    localparam int         RB_NBYTES_BASE = 22;

    // Position of the first (most significant) byte of each field in the frame.
    localparam logic [4:0] RB_IDX_HDR    = 5'd0;
    localparam logic [4:0] RB_IDX_PER    = 5'd1;
    localparam logic [4:0] RB_IDX_P1WID  = 5'd5;
    localparam logic [4:0] RB_IDX_DEL    = 5'd9;
    localparam logic [4:0] RB_IDX_P2WID  = 5'd13;
    localparam logic [4:0] RB_IDX_PBL    = 5'd17;
    localparam logic [4:0] RB_IDX_PBLOFF = 5'd18;
    localparam logic [4:0] RB_IDX_CP     = 5'd20;
    localparam logic [4:0] RB_IDX_FLAGS  = 5'd21;
    localparam logic [4:0] RB_IDX_CKSUM  = 5'd22;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_LOAD,
        FR_SEND
    } rb_frame_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

    typedef enum logic [2:0] {
        RB_FLAG_PU = 3'd0,
        RB_FLAG_BL = 3'd1
    } rb_flag_pos_t;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first byte serializer with per-bit timer
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   valid, data      byte offered for transmission
//   ready            byte accepted on valid && ready
//   byte_done        high during the final cycle of the stop bit
//   tx               serial line, idles high
//
// ready is also raised in the last stop-bit cycle so a waiting byte starts
// its start bit on the very next cycle (back-to-back bytes, no idle gap).
module uart_tx_byte
    import pulse_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    ser_state_t    state;
    ser_state_t    state_n;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_last;
    logic          accept;

    assign bit_last  = (bit_cnt == CNT_LAST);
    assign byte_done = (state == SER_STOP) && bit_last;
    assign ready     = (state == SER_IDLE) || byte_done;
    assign accept    = valid && ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SER_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            SER_IDLE:  if (valid) state_n = SER_START;
            SER_START: if (bit_last) state_n = SER_DATA;
            SER_DATA:  if (bit_last && (bit_idx == 3'd7)) state_n = SER_STOP;
            SER_STOP:  if (bit_last) state_n = valid ? SER_START : SER_IDLE;
            default:   state_n = SER_IDLE;
        endcase
    end

    // tx is registered: each bit value is set on the edge that ends the
    // previous bit, so the line changes exactly every CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (accept) begin
            shreg   <= data;
            tx      <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
        end else if (state != SER_IDLE) begin
            if (bit_last) begin
                bit_cnt <= '0;
                case (state)
                    SER_START: begin
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                    end
                    SER_DATA: begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx <= 1'b1;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end
                    default: tx <= 1'b1;
                endcase
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_readback_tx.sv
// rtl/param_readback_tx.sv - pulse-configuration readback frame transmitter
//
// Optional feature macro: READBACK_CKSUM_EN (appends an 8-bit additive
// checksum byte, 23-byte frame; otherwise 22 bytes).
//
// Ports:
//   clk, resetn                      12 MHz base clock, async active-low reset
//   req                              one-cycle readback request
//   per, p1wid, del, p2wid           32-bit pulse timing fields
//   p_bl, p_bl_off, cp               pulse block, block-off, CPMG count
//   pu, bl                           pump and block flags
//   RS232_Tx                         serial line, idles high
//   busy                             frame in progress
//   done                             one-cycle pulse after the last stop bit
module param_readback_tx
    import pulse_link_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] per,
    input  logic [31:0] p1wid,
    input  logic [31:0] del,
    input  logic [31:0] p2wid,
    input  logic [7:0]  p_bl,
    input  logic [15:0] p_bl_off,
    input  logic [7:0]  cp,
    input  logic        pu,
    input  logic        bl,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        done
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef READBACK_CKSUM_EN
    localparam int NBYTES = RB_NBYTES_BASE + 1;
`else
    localparam int NBYTES = RB_NBYTES_BASE;
`endif
    localparam logic [4:0] IDX_LAST = 5'(NBYTES - 1);

    rb_frame_state_t state;
    rb_frame_state_t state_n;
    logic [4:0]      byte_idx;
    logic [31:0]     per_q, p1wid_q, del_q, p2wid_q;
    logic [7:0]      p_bl_q, cp_q;
    logic [15:0]     p_bl_off_q;
    logic            pu_q, bl_q;
    logic [7:0]      flags;
    logic [7:0]      frame_byte;
    logic            take_req;
    logic            ser_valid;
    logic            ser_ready;
    logic            ser_done;
    logic            handoff;
`ifdef READBACK_CKSUM_EN
    logic [7:0]      cksum;
`endif

    // The header goes straight to the idle serializer on the accepting edge,
    // so the start bit appears one cycle after req with no LOAD bubble.
    assign take_req  = (state == FR_IDLE) && req;
    assign ser_valid = take_req || (state == FR_LOAD);
    assign handoff   = ser_valid && ser_ready;
    assign busy      = (state != FR_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            per_q      <= '0;
            p1wid_q    <= '0;
            del_q      <= '0;
            p2wid_q    <= '0;
            p_bl_q     <= '0;
            p_bl_off_q <= '0;
            cp_q       <= '0;
            pu_q       <= 1'b0;
            bl_q       <= 1'b0;
        end else if (take_req) begin
            per_q      <= per;
            p1wid_q    <= p1wid;
            del_q      <= del;
            p2wid_q    <= p2wid;
            p_bl_q     <= p_bl;
            p_bl_off_q <= p_bl_off;
            cp_q       <= cp;
            pu_q       <= pu;
            bl_q       <= bl;
        end
    end

    always_comb begin
        flags             = '0;
        flags[RB_FLAG_PU] = pu_q;
        flags[RB_FLAG_BL] = bl_q;
    end

    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            RB_IDX_HDR:           frame_byte = RB_HEADER;
            RB_IDX_PER:           frame_byte = per_q[31:24];
            RB_IDX_PER + 5'd1:    frame_byte = per_q[23:16];
            RB_IDX_PER + 5'd2:    frame_byte = per_q[15:8];
            RB_IDX_PER + 5'd3:    frame_byte = per_q[7:0];
            RB_IDX_P1WID:         frame_byte = p1wid_q[31:24];
            RB_IDX_P1WID + 5'd1:  frame_byte = p1wid_q[23:16];
            RB_IDX_P1WID + 5'd2:  frame_byte = p1wid_q[15:8];
            RB_IDX_P1WID + 5'd3:  frame_byte = p1wid_q[7:0];
            RB_IDX_DEL:           frame_byte = del_q[31:24];
            RB_IDX_DEL + 5'd1:    frame_byte = del_q[23:16];
            RB_IDX_DEL + 5'd2:    frame_byte = del_q[15:8];
            RB_IDX_DEL + 5'd3:    frame_byte = del_q[7:0];
            RB_IDX_P2WID:         frame_byte = p2wid_q[31:24];
            RB_IDX_P2WID + 5'd1:  frame_byte = p2wid_q[23:16];
            RB_IDX_P2WID + 5'd2:  frame_byte = p2wid_q[15:8];
            RB_IDX_P2WID + 5'd3:  frame_byte = p2wid_q[7:0];
            RB_IDX_PBL:           frame_byte = p_bl_q;
            RB_IDX_PBLOFF:        frame_byte = p_bl_off_q[15:8];
            RB_IDX_PBLOFF + 5'd1: frame_byte = p_bl_off_q[7:0];
            RB_IDX_CP:            frame_byte = cp_q;
            RB_IDX_FLAGS:         frame_byte = flags;
`ifdef READBACK_CKSUM_EN
            RB_IDX_CKSUM:         frame_byte = cksum;
`endif
            default:              frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= FR_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // LOAD presents byte_idx and holds it until the serializer frees up at
    // the end of the previous stop bit; SEND waits out the final byte.
    always_comb begin
        state_n = state;
        case (state)
            FR_IDLE: if (req) state_n = FR_LOAD;
            FR_LOAD: if (ser_ready && (byte_idx == IDX_LAST)) state_n = FR_SEND;
            FR_SEND: if (ser_done) state_n = FR_IDLE;
            default: state_n = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_idx <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FR_SEND) && ser_done;
            if (handoff) begin
                byte_idx <= (byte_idx == IDX_LAST) ? 5'd0 : byte_idx + 5'd1;
            end
        end
    end

`ifdef READBACK_CKSUM_EN
    // Restart from zero on the header so the sum covers exactly this frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cksum <= '0;
        end else if (handoff) begin
            cksum <= ((state == FR_IDLE) ? 8'h00 : cksum) + frame_byte;
        end
    end
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (ser_valid),
        .data      (frame_byte),
        .ready     (ser_ready),
        .byte_done (ser_done),
        .tx        (RS232_Tx)
    );

endmodule

// File: tb/tb_param_readback_tx.sv
// tb/tb_param_readback_tx.sv - scoreboard bench for param_readback_tx
module tb_param_readback_tx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 300;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef READBACK_CKSUM_EN
    localparam int NB = 23;
`else
    localparam int NB = 22;
`endif
    localparam int FRAME = NB * 10 * CPB;

    logic        clk;
    logic        resetn;
    logic        req;
    logic [31:0] per, p1wid, del, p2wid;
    logic [7:0]  p_bl, cp;
    logic [15:0] p_bl_off;
    logic        pu, bl;
    logic        RS232_Tx;
    logic        busy;
    logic        done;

    param_readback_tx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .per      (per),
        .p1wid    (p1wid),
        .del      (del),
        .p2wid    (p2wid),
        .p_bl     (p_bl),
        .p_bl_off (p_bl_off),
        .cp       (cp),
        .pu       (pu),
        .bl       (bl),
        .RS232_Tx (RS232_Tx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    task automatic push_frame();
        logic [7:0] b[$];
        logic [7:0] sum;
        b.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) b.push_back(per[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(p1wid[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(del[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(p2wid[8*i +: 8]);
        b.push_back(p_bl);
        b.push_back(p_bl_off[15:8]);
        b.push_back(p_bl_off[7:0]);
        b.push_back(cp);
        b.push_back({6'b0, bl, pu});
        sum = 8'h00;
        foreach (b[i]) sum = sum + b[i];
`ifdef READBACK_CKSUM_EN
        b.push_back(sum);
`endif
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    // Line monitor: decodes 8N1 by mid-bit sampling and scores each byte.
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_data = 8'h00;
    int         rx_bytes = 0;
    int         last_start_cyc = -1;
    int         busy_cnt = 0;
    int         tx_low_cnt = 0;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (RS232_Tx !== 1'b1) tx_low_cnt++;
        if (!resetn) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (RS232_Tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
                last_start_cyc = cyc;
            end
        end else begin
            rx_cnt++;
            for (int k = 0; k < 8; k++)
                if (rx_cnt == CPB / 2 + (k + 1) * CPB) rx_data[k] = RS232_Tx;
            if (rx_cnt == CPB / 2 + 9 * CPB) begin
                check_eq("stop_bit", 32'(RS232_Tx), 1);
                check_eq("byte_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_eq("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
                rx_act = 1'b0;
                rx_bytes++;
            end
        end
    end

    task automatic send_req(output int rc);
        @(negedge clk);
        req = 1'b1;
        rc  = cyc;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check_eq("done_seen", 32'(done), 1);
    endtask

    task automatic randomize_inputs();
        per      = $urandom();
        p1wid    = $urandom();
        del      = $urandom();
        p2wid    = $urandom();
        p_bl     = 8'($urandom());
        p_bl_off = 16'($urandom());
        cp       = 8'($urandom());
        pu       = 1'($urandom());
        bl       = 1'($urandom());
    endtask

    task automatic run_frame(input bit scramble, output int dc);
        int rc;
        busy_cnt = 0;
        push_frame();
        send_req(rc);
        if (scramble) randomize_inputs();
        #1;
        check_eq("start_latency", last_start_cyc - rc, 1);
        wait_done(FRAME + 20, dc);
        #1;
        check_eq("done_latency", dc - rc, FRAME + 1);
        check_eq("busy_cycles", busy_cnt, FRAME);
        check_eq("frame_bytes_left", exp_q.size(), 0);
        check_eq("busy_at_done", 32'(busy), 0);
        check_eq("line_idle_at_done", 32'(RS232_Tx), 1);
    endtask

    initial begin
        int dc, dc2, rc, base;
        resetn = 1'b0;
        req = 1'b0;
        per = '0; p1wid = '0; del = '0; p2wid = '0;
        p_bl = '0; p_bl_off = '0; cp = '0; pu = 1'b0; bl = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_tx", 32'(RS232_Tx), 1);
        check_eq("reset_busy", 32'(busy), 0);
        check_eq("reset_done", 32'(done), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // All-zero frame.
        run_frame(1'b0, dc);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 0);

        // per pattern with pump flag.
        per = 32'h12345678;
        pu  = 1'b1;
        run_frame(1'b0, dc);

        // Random fields, changed one cycle after the request.
        for (int t = 0; t < 2; t++) begin
            randomize_inputs();
            run_frame(1'b1, dc);
        end

        // Request while busy is dropped.
        randomize_inputs();
        push_frame();
        send_req(rc);
        repeat (5 * 10 * CPB) @(negedge clk);
        randomize_inputs();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(FRAME + 20, dc);
        #1;
        check_eq("ignored_req_done_latency", dc - rc, FRAME + 1);
        base = rx_bytes;
        tx_low_cnt = 0;
        repeat (3 * 10 * CPB) @(negedge clk);
        #1;
        check_eq("ignored_req_no_extra_bytes", rx_bytes - base, 0);
        check_eq("ignored_req_line_idle", tx_low_cnt, 0);
        check_eq("ignored_req_queue", exp_q.size(), 0);

        // Request on the done cycle starts the next frame one cycle later.
        randomize_inputs();
        run_frame(1'b0, dc);
        randomize_inputs();
        req = 1'b1;
        push_frame();
        @(negedge clk);
        req = 1'b0;
        #1;
        check_eq("req_on_done_start", last_start_cyc - dc, 1);
        wait_done(FRAME + 20, dc2);
        #1;
        check_eq("req_on_done_period", dc2 - dc, FRAME + 1);
        check_eq("req_on_done_queue", exp_q.size(), 0);

        // Reset during byte 7 abandons the frame.
        randomize_inputs();
        base = rx_bytes;
        push_frame();
        send_req(rc);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (rx_bytes - base >= 7) break;
        end
        check_eq("reached_byte7", 32'(rx_bytes - base >= 7), 1);
        repeat (CPB * 4) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_reset_tx", 32'(RS232_Tx), 1);
        check_eq("async_reset_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        tx_low_cnt = 0;
        base = rx_bytes;
        repeat (4 * 10 * CPB) @(negedge clk);
        #1;
        check_eq("post_reset_line_idle", tx_low_cnt, 0);
        check_eq("post_reset_busy", 32'(busy), 0);
        check_eq("post_reset_no_bytes", rx_bytes - base, 0);

        // Link still works after the abandoned frame.
        randomize_inputs();
        run_frame(1'b0, dc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
